switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
Input-conditioning stage that sits directly upstream of the cycled displayer core. Raw board slide switches (run-enable, reset request, mode bits) go through a two-flop synchronizer, then a per-channel debounce counter. The block drives clean level outputs plus single-cycle rise/fall pulses, so the displayer's en/rst inputs never see metastable or bouncing values.

Parameters:
WIDTH, 2, number of independent switch channels (>=1)
FREQ, 25_000_000, clk frequency in Hz
DEBOUNCE_MS, 10, required stable time in ms
DB_CYCLES (localparam), FREQ/1000*DEBOUNCE_MS clamped to >=1, stable-cycle count; counter width $clog2(DB_CYCLES+1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
sw_in  input  WIDTH  raw asynchronous switch levels
sw_level  output  WIDTH  debounced, synchronized switch level
sw_rise  output  WIDTH  one-cycle pulse when sw_level[i] goes 0->1
sw_fall  output  WIDTH  one-cycle pulse when sw_level[i] goes 1->0
sw_toggle  output  WIDTH  toggle state per channel (see Optional Feature)

Behaviour:
- Reset (rst=0, async): sync flops, counters, sw_level, sw_rise, sw_fall, sw_toggle all 0. Effect is immediate, independent of clk. Release is sampled on the next clk edge.
- Sync: two registered stages per channel, s1 <= sw_in, s2 <= s1. Only s2 feeds the debouncer.
- Debounce per channel i, using counter cnt[i]:
  - s2[i] == sw_level[i]: cnt[i] <= 0.
  - s2[i] != sw_level[i] and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != sw_level[i] and cnt[i] == DB_CYCLES-1: sw_level[i] <= s2[i], cnt[i] <= 0.
- Latency: a clean step on sw_in[i] before edge k makes s2 differ from edge k+1. sw_level flips at edge k+1+DB_CYCLES, so it is visible DB_CYCLES+2 edges after the step.
- Glitch rejection: any excursion of s2 lasting fewer than DB_CYCLES cycles restarts cnt at 0 and sw_level does not change. A bounce inside the window restarts the full count.
- Pulses are registered and update at the same edge as sw_level:
  - sw_rise[i] is high for exactly the first cycle in which sw_level[i]=1.
  - sw_fall[i] is high for exactly the first cycle in which sw_level[i]=0 after being 1.
  - Never both high on one channel. Channels are fully independent; simultaneous events on different channels each produce their own pulse.
- DB_CYCLES==1: sw_level follows s2 with one extra cycle of delay. Pulse rules are unchanged.
- Reset mid-count: counter and level are cleared. A switch held at 1 through reset release produces a normal rise pulse DB_CYCLES+2 edges after release.
- Counter never wraps: it saturates by design at DB_CYCLES-1 and then clears.

Optional Feature:
Macro SW_TOGGLE_EN.
- Defined: sw_toggle[i] is a register that inverts at each edge where sw_rise[i] is asserted. It resets to 0 and is used to turn a momentary switch/key into a latched enable.
- Undefined: sw_toggle is tied to all zeros and no toggle registers are built.
- sw_level, sw_rise and sw_fall behave identically in both builds.

Test Plan:
- Bench parameters for all tests: FREQ=1000, DEBOUNCE_MS=4, so DB_CYCLES=4; WIDTH=2.
- Reset: rst=0 with sw_in=2'b11 -> all outputs 0 immediately. Release rst -> sw_level=2'b11 six edges later, sw_rise=2'b11 for exactly that one cycle.
- Clean step: sw_in[0] 0->1 and held -> sw_level[0]=1 after 6 edges, sw_rise[0] one cycle, sw_fall=0 and channel 1 unaffected. Return to 0 -> sw_fall[0] one cycle after 6 edges.
- Bounce: sw_in[0] pattern 1,0,1,1,0 (one cycle each), then held 1 -> no rise during bounce; sw_level[0]=1 exactly 6 edges after the final 0->1, one rise pulse total.
- Short glitch: sw_in[1]=1 for 3 cycles, then 0 -> sw_level[1] stays 0, no pulses.
- Async reset mid-count: sw_in[0]=1, assert rst after 3 cycles -> cnt/level 0 at once. Release with sw_in[0] still 1 -> rise 6 edges after release.
- SW_TOGGLE_EN defined: three clean presses on channel 0 -> sw_toggle[0] goes 1,0,1, each change coinciding with a sw_rise[0] pulse. Undefined: sw_toggle stays 0.

Source files
------------

// File: rtl/switch_conditioner.sv
// ---------------------------------------------------------------------------
// switch_conditioner
//
// Cleans up raw board slide switches before they reach the cycled displayer
// core. Each channel passes through a two-flop synchronizer and then a
// debounce counter. The output level changes only after the synchronized
// input has disagreed with it for DB_CYCLES consecutive cycles. Single-cycle
// rise and fall pulses are registered at the same edge as the level change.
//
// Optional feature, selected with the macro SW_TOGGLE_EN:
//   defined   - sw_toggle[i] inverts at every edge that raises sw_rise[i].
//               This turns a momentary key into a latched enable.
//   undefined - sw_toggle is tied to zero and no toggle registers exist.
//
// Parameters:
//   WIDTH        number of independent switch channels (>= 1)
//   FREQ         clk frequency in Hz
//   DEBOUNCE_MS  required stable time in milliseconds
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   sw_in      in   WIDTH  raw asynchronous switch levels
//   sw_level   out  WIDTH  debounced, synchronized level
//   sw_rise    out  WIDTH  one-cycle pulse on a level 0->1 change
//   sw_fall    out  WIDTH  one-cycle pulse on a level 1->0 change
//   sw_toggle  out  WIDTH  per-channel toggle state (zero unless SW_TOGGLE_EN)
// ---------------------------------------------------------------------------
module switch_conditioner #(
    parameter int WIDTH       = 2,
    parameter int FREQ        = 25_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_level,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] sw_toggle
);

    // A very slow clock or a zero stable time would give a count of 0.
    // Clamp it to 1 so the level still changes after one stable cycle.
    localparam int DB_RAW    = FREQ / 1000 * DEBOUNCE_MS;
    localparam int DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int CNT_W     = $clog2(DB_CYCLES + 1);

    // The counter reaches this value on the last mismatching cycle and
    // then clears, so it can never wrap.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0]            s1;
    logic [WIDTH-1:0]            s2;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]            level_nxt;
    logic [WIDTH-1:0]            rise_nxt;
    logic [WIDTH-1:0]            fall_nxt;

    // Two-stage synchronizer. Only s2 may be used downstream. s1 is allowed
    // to go metastable and gets a full cycle to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // Per-channel debounce decision. Any cycle where s2 agrees with the
    // current level clears the count, so a bounce inside the window forces
    // a full restart. When the count is already at its maximum and s2 still
    // disagrees, the level takes the value of s2. The matching edge pulse is
    // produced in the same cycle, so it lines up with the new level.
    always_comb begin
        level_nxt = sw_level;
        rise_nxt  = '0;
        fall_nxt  = '0;
        cnt_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] != sw_level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = s2[i];
                    rise_nxt[i]  = s2[i];
                    fall_nxt[i]  = ~s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state and registered outputs. The pulses are registered here
    // so that they can never glitch on their way to the displayer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            sw_level <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
        end else begin
            cnt      <= cnt_nxt;
            sw_level <= level_nxt;
            sw_rise  <= rise_nxt;
            sw_fall  <= fall_nxt;
        end
    end

`ifdef SW_TOGGLE_EN
    // Latched toggle. It flips at the same edge that raises sw_rise, so each
    // change of the toggle appears in the same cycle as its rise pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_toggle <= '0;
        end else begin
            sw_toggle <= sw_toggle ^ rise_nxt;
        end
    end
`else
    // Feature disabled: the toggle output is held at zero.
    assign sw_toggle = '0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// ---------------------------------------------------------------------------
// tb_switch_conditioner
//
// Directed test of switch_conditioner with FREQ=1000 and DEBOUNCE_MS=4, which
// gives DB_CYCLES=4 and WIDTH=2. A clean input step therefore shows up on
// sw_level six rising edges after it is applied.
//
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_switch_conditioner;

    logic       clk;
    logic       rst;
    logic [1:0] sw_in;
    logic [1:0] sw_level;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic [1:0] sw_toggle;

    int checks = 0;
    int errors = 0;

    switch_conditioner #(
        .WIDTH       (2),
        .FREQ        (1000),
        .DEBOUNCE_MS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .sw_level  (sw_level),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_toggle (sw_toggle)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected sequence end");
        $fatal(1, "[TB] watchdog expired");
    end

    // In the default build the toggle output must stay 0. In this case the
    // hand-computed toggle value is replaced by 0.
    function automatic logic [1:0] tgl(input logic [1:0] v);
`ifdef SW_TOGGLE_EN
        return v;
`else
        return 2'b00 & v;
`endif
    endfunction

    // Drive the raw switches and the reset line.
    task automatic applyStimulus(input logic [1:0] sw, input logic rst_v);
        sw_in = sw;
        rst   = rst_v;
    endtask

    // Advance n rising edges, then settle 1 unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare all four outputs at once against the hand-computed values.
    task automatic checkOutput(input string tag, input logic [1:0] lvl,
                               input logic [1:0] rise, input logic [1:0] fall,
                               input logic [1:0] tog);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {sw_level, sw_rise, sw_fall, sw_toggle};
        exp = {lvl, rise, fall, tgl(tog)};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed lvl/rise/fall/tog=%b expected %b",
                   tag, obs, exp);
        end
    endtask

    // Apply a clean change. Check that nothing moves after five edges, then
    // check the level change and pulse on the sixth edge. Finally check that
    // the pulse has gone on the seventh edge.
    task automatic cleanStep(input string tag, input logic [1:0] sw,
                             input logic [1:0] lvl_old, input logic [1:0] lvl_new,
                             input logic [1:0] rise, input logic [1:0] fall,
                             input logic [1:0] tog_old, input logic [1:0] tog_new);
        applyStimulus(sw, 1'b1);
        tick(5);
        checkOutput({tag, "_edge5"}, lvl_old, 2'b00, 2'b00, tog_old);
        tick(1);
        checkOutput({tag, "_edge6"}, lvl_new, rise, fall, tog_new);
        tick(1);
        checkOutput({tag, "_edge7"}, lvl_new, 2'b00, 2'b00, tog_new);
    endtask

    initial begin
        // Asynchronous reset with both switches already high.
        applyStimulus(2'b11, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_immediate", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(3);
        checkOutput("reset_held", 2'b00, 2'b00, 2'b00, 2'b00);

        // Release reset with both switches high. Both channels rise together
        // six edges later.
        cleanStep("release", 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11);

        // Both channels fall together.
        cleanStep("both_fall", 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);

        // Clean step on channel 0 only. Channel 1 must stay quiet.
        cleanStep("ch0_rise", 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10);
        cleanStep("ch0_fall", 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10);

        // Bounce pattern 1,0,1,1,0 on channel 0, then hold it at 1.
        applyStimulus(2'b01, 1'b1); tick(1);
        checkOutput("bounce_e1", 2'b00, 2'b00, 2'b00, 2'b10);
        applyStimulus(2'b00, 1'b1); tick(1);
        checkOutput("bounce_e2", 2'b00, 2'b00, 2'b00, 2'b10);
        applyStimulus(2'b01, 1'b1); tick(1);
        checkOutput("bounce_e3", 2'b00, 2'b00, 2'b00, 2'b10);
        tick(1);
        checkOutput("bounce_e4", 2'b00, 2'b00, 2'b00, 2'b10);
        applyStimulus(2'b00, 1'b1); tick(1);
        checkOutput("bounce_e5", 2'b00, 2'b00, 2'b00, 2'b10);
        applyStimulus(2'b01, 1'b1);
        for (int e = 6; e <= 10; e++) begin
            tick(1);
            checkOutput($sformatf("bounce_e%0d", e), 2'b00, 2'b00, 2'b00, 2'b10);
        end
        tick(1);
        checkOutput("bounce_e11_rise", 2'b01, 2'b01, 2'b00, 2'b11);
        tick(1);
        checkOutput("bounce_e12", 2'b01, 2'b00, 2'b00, 2'b11);

        // Channel 1 is high for only three cycles. The glitch is rejected.
        applyStimulus(2'b11, 1'b1);
        tick(3);
        applyStimulus(2'b01, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            checkOutput($sformatf("glitch_%0d", e), 2'b01, 2'b00, 2'b00, 2'b11);
        end

        // Bring channel 0 back to 0 before the mid-count reset test.
        cleanStep("pre_rst_fall", 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11);

        // Channel 0 goes high. Reset is asserted partway through the debounce
        // count.
        applyStimulus(2'b01, 1'b1);
        tick(3);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midcount_rst_now", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(2);
        checkOutput("midcount_rst_held", 2'b00, 2'b00, 2'b00, 2'b00);

        // Release reset while the switch is still held high. This is the
        // first press after reset.
        cleanStep("rst_release_ch0", 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);

        // Second and third presses: the toggle goes 0, then 1.
        cleanStep("press2_up", 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        cleanStep("press2_dn", 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00);
        cleanStep("press3_up", 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        cleanStep("press3_dn", 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
